// File: rtl/multiplier_pkg.sv
// Shared constants and types for the Barrett reduction datapath and its scheduler.
package multiplier_pkg;

  // Multiplier stages inside the pipelined Barrett reducer
  localparam int NUM_MULS = 4;

  // Default number of requesters sharing one reducer
  localparam int NUM_REQ_DEF = 4;

  // Reducer latency from start to result valid
  localparam int RED_LAT_DEF = (NUM_MULS + 2) * 2 + 1;

  // Scheduler control states
  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // In-flight counter width: holds 0..lat with one bit of headroom
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk requesters in rotated order and grant the first one that is asking
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrett_scheduler.sv
// Shares one pipelined Barrett reducer between NUM_REQ requesters: round-robin
// issue, modulus reconfiguration with drain, tag tracking and result routing.
module barrett_scheduler
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int RED_LAT = RED_LAT_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0][63:0]     req_x_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [63:0]                  cfg_m_i,
  input  logic [63:0]                  cfg_m_bl_i,
  input  logic [63:0]                  cfg_mu_i,
  output logic                         red_start_o,
  output logic [63:0]                  red_x_o,
  output logic [63:0]                  red_m_o,
  output logic [63:0]                  red_m_bl_o,
  output logic [63:0]                  red_mu_o,
  input  logic                         red_valid_i,
  input  logic [63:0]                  red_result_i,
  output logic                         rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [63:0]                  rsp_data_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(RED_LAT);

  sched_state_e state_q, state_d;
  logic [63:0]  m_q, m_d;
  logic [63:0]  m_bl_q, m_bl_d;
  logic [63:0]  mu_q, mu_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [RED_LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [RED_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic               grant_en;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic               cnt_zero;
  logic               cfg_hs;
  logic               tag_out_vld;
  logic [ID_W-1:0]    tag_out_id;

  // Grants only while running with no reconfiguration pending
  assign grant_en = (state_q == ST_RUN) && !cfg_valid_i && !rst_i;
  assign arb_req  = req_valid_i & {NUM_REQ{grant_en}};

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req_i (arb_req),
    .ptr_i (last_q),
    .gnt_o (gnt)
  );

  assign gnt_any = |gnt;

  // Encode the one-hot grant into a requester index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = ID_W'(i);
    end
  end

  // Issue straight to the reducer in the grant cycle
  assign req_ready_o = gnt;
  assign red_start_o = gnt_any;
  assign red_x_o     = gnt_any ? req_x_i[gnt_idx] : '0;
  assign red_m_o     = m_q;
  assign red_m_bl_o  = m_bl_q;
  assign red_mu_o    = mu_q;

  assign cnt_zero = (cnt_q == '0);

  // Config is accepted unconfigured, or once nothing is in flight
  always_comb begin
    cfg_ready_o = 1'b0;
    case (state_q)
      ST_UNCFG: cfg_ready_o = 1'b1;
      ST_RUN:   cfg_ready_o = cnt_zero && !gnt_any;
      ST_DRAIN: cfg_ready_o = cnt_zero;
      default:  cfg_ready_o = 1'b0;
    endcase
    if (rst_i) cfg_ready_o = 1'b0;
  end

  assign cfg_hs = cfg_valid_i && cfg_ready_o;

  // Tag pipeline mirrors the reducer latency; stage 0 captures each issue
  assign tag_vld_d[0] = gnt_any;
  assign tag_id_d[0]  = gnt_idx;
  for (genvar gi = 1; gi < RED_LAT; gi++) begin : g_tag_shift
    assign tag_vld_d[gi] = tag_vld_q[gi-1];
    assign tag_id_d[gi]  = tag_id_q[gi-1];
  end

  assign tag_out_vld = tag_vld_q[RED_LAT-1];
  assign tag_out_id  = tag_id_q[RED_LAT-1];

  // Next-state: FSM, config latch, grant pointer, in-flight count, response and error
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    m_bl_d  = m_bl_q;
    mu_d    = mu_q;
    case (state_q)
      ST_UNCFG: if (cfg_hs) state_d = ST_RUN;
      ST_RUN:   if (cfg_valid_i && !cfg_hs) state_d = ST_DRAIN;
      ST_DRAIN: if (cfg_hs) state_d = ST_RUN;
      default:  state_d = ST_UNCFG;
    endcase
    if (cfg_hs) begin
      m_d    = cfg_m_i;
      m_bl_d = cfg_m_bl_i;
      mu_d   = cfg_mu_i;
    end

    last_d = gnt_any ? gnt_idx : last_q;

    cnt_d = cnt_q;
    if (gnt_any && !tag_out_vld) cnt_d = cnt_q + CNT_W'(1);
    else if (!gnt_any && tag_out_vld) cnt_d = cnt_q - CNT_W'(1);

    // A result is routed only when reducer and tag pipeline agree
    rsp_valid_d = red_valid_i && tag_out_vld;
    rsp_id_d    = rsp_valid_d ? tag_out_id : rsp_id_q;
    rsp_data_d  = rsp_valid_d ? red_result_i : rsp_data_q;
    err_d       = err_q | (red_valid_i != tag_out_vld);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_UNCFG;
      m_q         <= '0;
      m_bl_q      <= '0;
      mu_q        <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      m_bl_q      <= m_bl_d;
      mu_q        <= mu_d;
      last_q      <= last_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = !cnt_zero;
  assign err_o       = err_q;

endmodule

// File: tb/tb_barrett_scheduler.sv
// Bench for barrett_scheduler: a behavioural reducer plus a scoreboard of
// expected grants, config readiness, routed results and error state.
module tb_barrett_scheduler;

  localparam int NUM_REQ = 4;
  localparam int RED_LAT = (multiplier_pkg::NUM_MULS + 2) * 2 + 1;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0][63:0] req_x_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     cfg_valid_i;
  logic                     cfg_ready_o;
  logic [63:0]              cfg_m_i, cfg_m_bl_i, cfg_mu_i;
  logic                     red_start_o;
  logic [63:0]              red_x_o, red_m_o, red_m_bl_o, red_mu_o;
  logic                     red_valid_i;
  logic [63:0]              red_result_i;
  logic                     rsp_valid_o;
  logic [1:0]               rsp_id_o;
  logic [63:0]              rsp_data_o;
  logic                     busy_o, err_o;

  always #5 clk = ~clk;

  barrett_scheduler #(.NUM_REQ(NUM_REQ), .RED_LAT(RED_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_x_i      (req_x_i),
    .req_ready_o  (req_ready_o),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_m_i      (cfg_m_i),
    .cfg_m_bl_i   (cfg_m_bl_i),
    .cfg_mu_i     (cfg_mu_i),
    .red_start_o  (red_start_o),
    .red_x_o      (red_x_o),
    .red_m_o      (red_m_o),
    .red_m_bl_o   (red_m_bl_o),
    .red_mu_o     (red_mu_o),
    .red_valid_i  (red_valid_i),
    .red_result_i (red_result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  typedef struct { int due; logic [63:0] val; } red_t;
  typedef struct { int due; int id; logic [63:0] data; } exp_t;

  red_t red_q[$];   // operations inside the external reducer
  exp_t exp_q[$];   // responses the scheduler owes, by cycle
  int   dut_gnt_log[$];
  int   rsp_id_log[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  bit          mdl_cfgd, mdl_drain, mdl_err;
  int          mdl_last;
  logic [63:0] mdl_m, mdl_bl, mdl_mu;
  bit          inject;
  bit          hs_seen;
  int          hs_cyc;
  int          last_gnt_cyc, last_rsp_cyc, last_rsp_id;
  logic [63:0] last_rsp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic mdl_reset();
    exp_q.delete();
    mdl_cfgd  = 1'b0;
    mdl_drain = 1'b0;
    mdl_err   = 1'b0;
    mdl_last  = NUM_REQ - 1;
    mdl_m     = '0;
    mdl_bl    = '0;
    mdl_mu    = '0;
  endtask

  // One clock cycle: check outputs at the falling edge, play the reducer, advance models
  task automatic step();
    int                 exp_idx;
    logic [NUM_REQ-1:0] exp_gnt;
    bit                 exp_rsp, busy_now, exp_cfg_rdy, hs, drv, tag_due;
    int                 g;
    @(negedge clk);

    exp_rsp = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    chk("rsp_valid", rsp_valid_o, exp_rsp);
    if (exp_rsp) begin
      chk("rsp_id", rsp_id_o, exp_q[0].id);
      chk("rsp_data", rsp_data_o, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    if (rsp_valid_o) begin
      last_rsp_cyc  = cyc;
      last_rsp_id   = rsp_id_o;
      last_rsp_data = rsp_data_o;
      rsp_id_log.push_back(int'(rsp_id_o));
    end
    busy_now = (exp_q.size() != 0);
    chk("busy", busy_o, busy_now);
    chk("err", err_o, mdl_err);

    exp_gnt = '0;
    exp_idx = -1;
    if (!rst_i && mdl_cfgd && !mdl_drain && !cfg_valid_i) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (mdl_last + k) % NUM_REQ;
        if (exp_idx < 0 && req_valid_i[i]) exp_idx = i;
      end
    end
    if (exp_idx >= 0) exp_gnt[exp_idx] = 1'b1;
    chk("req_ready", req_ready_o, exp_gnt);
    chk("red_start", red_start_o, exp_idx >= 0);
    if (red_start_o) begin
      g = 0;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) g = i;
      dut_gnt_log.push_back(g);
    end
    if (exp_idx >= 0) begin
      chk("red_x", red_x_o, req_x_i[exp_idx]);
      chk("red_m", red_m_o, mdl_m);
      chk("red_m_bl", red_m_bl_o, mdl_bl);
      chk("red_mu", red_mu_o, mdl_mu);
      exp_q.push_back('{cyc + RED_LAT + 1, exp_idx, req_x_i[exp_idx] % mdl_m});
      mdl_last     = exp_idx;
      last_gnt_cyc = cyc;
    end

    if (rst_i)          exp_cfg_rdy = 1'b0;
    else if (!mdl_cfgd) exp_cfg_rdy = 1'b1;
    else if (mdl_drain) exp_cfg_rdy = !busy_now;
    else                exp_cfg_rdy = !busy_now && (exp_idx < 0);
    chk("cfg_ready", cfg_ready_o, exp_cfg_rdy);
    hs = cfg_valid_i && exp_cfg_rdy;
    if (hs) begin
      mdl_cfgd  = 1'b1;
      mdl_drain = 1'b0;
      mdl_m     = cfg_m_i;
      mdl_bl    = cfg_m_bl_i;
      mdl_mu    = cfg_mu_i;
      hs_seen   = 1'b1;
      hs_cyc    = cyc;
    end else if (!rst_i && mdl_cfgd && !mdl_drain && cfg_valid_i) begin
      mdl_drain = 1'b1;
    end

    // External reducer: returns x mod m exactly RED_LAT cycles after start
    drv          = inject;
    red_result_i = '0;
    if (red_q.size() != 0 && red_q[0].due == cyc) begin
      drv          = 1'b1;
      red_result_i = red_q[0].val;
      void'(red_q.pop_front());
    end
    red_valid_i = drv;
    if (red_start_o) red_q.push_back('{cyc + RED_LAT, red_x_o % red_m_o});

    tag_due = 1'b0;
    foreach (exp_q[j]) if (exp_q[j].due == cyc + 1) tag_due = 1'b1;
    if (drv != tag_due) mdl_err = 1'b1;

    if (rst_i) mdl_reset();

    @(posedge clk);
    #1;
    cyc++;
    red_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic do_cfg(input logic [63:0] m, input logic [63:0] bl, input logic [63:0] mu);
    cfg_valid_i = 1'b1;
    cfg_m_i     = m;
    cfg_m_bl_i  = bl;
    cfg_mu_i    = mu;
    hs_seen     = 1'b0;
    for (int n = 0; n < 200 && !hs_seen; n++) step();
    chk("cfg_handshake", hs_seen, 1'b1);
    cfg_valid_i = 1'b0;
  endtask

  task automatic rand_x();
    for (int i = 0; i < NUM_REQ; i++) req_x_i[i] = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({pfx, "_rsp_id"}, rsp_id_o, 0);
    chk({pfx, "_rsp_data"}, rsp_data_o, 0);
    chk({pfx, "_err"}, err_o, 1'b0);
    chk({pfx, "_busy"}, busy_o, 1'b0);
    chk({pfx, "_red_start"}, red_start_o, 1'b0);
    chk({pfx, "_req_ready"}, req_ready_o, 0);
    chk({pfx, "_cfg_ready"}, cfg_ready_o, 1'b1);
    chk({pfx, "_red_m"}, red_m_o, 0);
    chk({pfx, "_red_mu"}, red_mu_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int cfg_start;
    rst_i        = 1'b1;
    req_valid_i  = '0;
    req_x_i      = '0;
    cfg_valid_i  = 1'b0;
    cfg_m_i      = '0;
    cfg_m_bl_i   = '0;
    cfg_mu_i     = '0;
    red_valid_i  = 1'b0;
    red_result_i = '0;
    inject       = 1'b0;
    mdl_reset();

    // Reset values
    do_reset();
    chk_reset_outputs("reset");

    // Requests before any configuration are never granted
    req_valid_i = '1;
    rand_x();
    idle(4);
    req_valid_i = '0;

    // Single request from requester 2: 1000 mod 97 = 30
    do_cfg(64'd97, 64'd7, 64'd168);
    req_valid_i  = 4'b0100;
    req_x_i[2]   = 64'd1000;
    last_rsp_cyc = -1;
    step();
    req_valid_i = '0;
    idle(RED_LAT + 3);
    chk("single_latency", last_rsp_cyc - last_gnt_cyc, RED_LAT + 1);
    chk("single_id", last_rsp_id, 2);
    chk("single_data", last_rsp_data, 64'd30);

    // Continuous requests: strict 0,1,2,3 rotation and matching response order
    do_reset();
    do_cfg(64'd97, 64'd7, 64'd168);
    dut_gnt_log.delete();
    rsp_id_log.delete();
    req_valid_i = '1;
    for (int i = 0; i < 16; i++) begin
      rand_x();
      step();
    end
    req_valid_i = '0;
    idle(RED_LAT + 3);
    chk("stream_grants", dut_gnt_log.size(), 16);
    chk("stream_rsps", rsp_id_log.size(), 16);
    for (int i = 0; i < 16 && i < dut_gnt_log.size() && i < rsp_id_log.size(); i++) begin
      chk("stream_gnt_order", dut_gnt_log[i], i % NUM_REQ);
      chk("stream_rsp_order", rsp_id_log[i], i % NUM_REQ);
    end

    // Random request patterns and operands
    for (int i = 0; i < 80; i++) begin
      req_valid_i = NUM_REQ'($urandom);
      rand_x();
      step();
    end
    req_valid_i = '0;
    idle(RED_LAT + 3);

    // Reconfigure with five operations in flight
    req_valid_i = '1;
    for (int i = 0; i < 5; i++) begin
      rand_x();
      step();
    end
    cfg_start = cyc;
    cfg_valid_i = 1'b1;
    cfg_m_i     = 64'd1009;
    cfg_m_bl_i  = 64'd10;
    cfg_mu_i    = 64'd1039;
    hs_seen     = 1'b0;
    for (int n = 0; n < 100 && !hs_seen; n++) begin
      rand_x();
      step();
    end
    chk("drain_handshake", hs_seen, 1'b1);
    chk("drain_wait", hs_cyc - cfg_start, RED_LAT);
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_x();
      step();
    end
    req_valid_i = '0;
    idle(RED_LAT + 3);
    chk("new_mod_data", last_rsp_data, req_x_i[last_rsp_id] % 64'd1009);

    // Spurious reducer result with nothing in flight
    do_reset();
    do_cfg(64'd97, 64'd7, 64'd168);
    idle(2);
    inject = 1'b1;
    step();
    inject = 1'b0;
    idle(5);
    chk("inject_err_sticky", err_o, 1'b1);
    chk("inject_no_rsp", rsp_valid_o, 1'b0);

    // Reset with three operations in flight; stale results then flag an error
    do_reset();
    do_cfg(64'd251, 64'd8, 64'd261);
    req_valid_i = '1;
    for (int i = 0; i < 3; i++) begin
      rand_x();
      step();
    end
    req_valid_i = '0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    idle(RED_LAT + 3);
    chk("stale_err", err_o, 1'b1);
    chk("stale_no_rsp", rsp_valid_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
